data_memory_arbiter: RTL and testbench

// - Shares the single data-memory port between instruction fetch (port F, read-only) and the load/store unit (port L, read/write).
// - The memory port carries enable, memory_state, frame_mask, address and data, and completes with a done handshake.
// - Sits between the fetch/LSU requesters and the memory interface. At most one transaction is outstanding.
// - For each transaction it latches the command, waits for done (or a timeout) and returns a one-cycle ack.

---
 rtl/data_memory_arbiter_pkg.sv | 24 ++
 rtl/arb_priority_select.sv | 53 +++++
 rtl/data_memory_arbiter.sv | 168 ++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// - Memory command encoding (READ/WRITE), shared with the memory interface.
// - Arbiter FSM state encoding.
// - Requester port identifiers.
package data_memory_arbiter_pkg;

  // memory_state encoding on the memory port
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Requester identifiers: F = instruction fetch, L = load/store unit
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_L = 1'b1;

  // Fetch always reads a full word
  localparam logic [3:0] FULL_MASK = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_priority_select.sv
// Winner selection between fetch (F) and load/store (L) requests.
// L normally wins. The streak counter counts consecutive L grants that were
// made while F was also waiting; once it reaches L_STREAK_MAX a waiting F is
// granted next, so fetch cannot be starved.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   f_req, l_req   pending requests
//   grant_en       a grant is being made this cycle (arbiter IDLE with a request)
//   grant_port     winner (PORT_F / PORT_L), meaningful while grant_en=1
module arb_priority_select
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned L_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic f_req,
  input  logic l_req,
  input  logic grant_en,
  output logic grant_port
);

  localparam int unsigned SW = $clog2(L_STREAK_MAX + 1);

  logic [SW-1:0] streak;
  logic          f_forced;

  assign f_forced = (streak == SW'(L_STREAK_MAX));

  always_comb begin
    grant_port = PORT_L;
    if (f_req && (!l_req || f_forced)) begin
      grant_port = PORT_F;
    end
  end

  // Only L grants that bypassed a waiting F extend the streak; any other
  // grant restarts it. Saturates at L_STREAK_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_en) begin
      if (grant_port == PORT_L && f_req) begin
        if (!f_forced) begin
          streak <= streak + 1'b1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single data-memory port between instruction fetch (F, read-only)
// and the load/store unit (L, read/write). One transaction outstanding at a
// time: IDLE arbitrates and latches the command, BUSY drives the memory port
// until mem_done or timeout, RESP pulses the owner's ack for one cycle.
//
// Handshake: a requester raises req with its fields and holds all of them
// stable until it sees its one-cycle ack; rdata (and err) are valid only in
// the ack cycle, rdata then holds until the next read ack on that port. The
// memory sees mem_enable=1 for the whole transaction and answers with a
// single-cycle mem_done (with mem_rdata for reads); mem_done outside BUSY is
// ignored.
//
// Ports:
//   CLK, reset_n                   clock, asynchronous active-low reset
//   f_req/f_address/f_ack/f_rdata  fetch port
//   l_req/l_write/l_frame_mask/l_address/l_wdata/l_ack/l_rdata  LSU port
//   err                            timeout flag, pulses with the ack
//   mem_enable/mem_state/mem_frame_mask/mem_address/mem_wdata  memory command
//   mem_rdata/mem_done             memory response
//   fsm_state                      current arbiter state (debug)
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned L_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_address,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        l_req,
  input  logic        l_write,
  input  logic [3:0]  l_frame_mask,
  input  logic [31:0] l_address,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic [31:0] l_rdata,
  output logic        err,
  output logic        mem_enable,
  output logic        mem_state,
  output logic [3:0]  mem_frame_mask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output arb_state_t  fsm_state
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_t    state;
  arb_state_t    state_next;
  logic          grant_en;
  logic          grant_port;
  logic          owner;
  logic          err_q;
  logic [TW-1:0] timer;
  logic          timeout_hit;

  assign grant_en    = (state == IDLE) && (f_req || l_req);
  assign timeout_hit = (state == BUSY) && !mem_done && (timer == TW'(TIMEOUT - 1));

  arb_priority_select #(
    .L_STREAK_MAX (L_STREAK_MAX)
  ) u_select (
    .clk        (CLK),
    .rst_n      (reset_n),
    .f_req      (f_req),
    .l_req      (l_req),
    .grant_en   (grant_en),
    .grant_port (grant_port)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_en) state_next = BUSY;
      BUSY:    if (mem_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- command latch ----------------
  // The command is captured at grant time so the memory port stays stable
  // through BUSY regardless of what the requester does afterwards.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      owner          <= PORT_F;
      mem_state      <= MEM_READ;
      mem_frame_mask <= '0;
      mem_address    <= '0;
      mem_wdata      <= '0;
    end else if (grant_en) begin
      owner <= grant_port;
      if (grant_port == PORT_L) begin
        mem_state      <= l_write;
        mem_frame_mask <= l_frame_mask;
        mem_address    <= l_address;
        mem_wdata      <= l_wdata;
      end else begin
        mem_state      <= MEM_READ;
        mem_frame_mask <= FULL_MASK;
        mem_address    <= f_address;
        mem_wdata      <= '0;
      end
    end
  end

  // ---------------- timer and error flag ----------------
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
      err_q <= 1'b0;
    end else if (grant_en) begin
      timer <= '0;
      err_q <= 1'b0;
    end else if (state == BUSY) begin
      timer <= timer + 1'b1;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // ---------------- read data ----------------
  // A store completion leaves l_rdata alone; a timeout zeroes the owner's
  // rdata so a stale value is never returned alongside err.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      f_rdata <= '0;
      l_rdata <= '0;
    end else if (state == BUSY) begin
      if (mem_done) begin
        if (owner == PORT_F) begin
          f_rdata <= mem_rdata;
        end else if (mem_state == MEM_READ) begin
          l_rdata <= mem_rdata;
        end
      end else if (timeout_hit) begin
        if (owner == PORT_F) begin
          f_rdata <= '0;
        end else begin
          l_rdata <= '0;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign mem_enable = (state == BUSY);
  assign f_ack      = (state == RESP) && (owner == PORT_F);
  assign l_ack      = (state == RESP) && (owner == PORT_L);
  assign err        = (state == RESP) && err_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  logic        f_req = 1'b0;
  logic [31:0] f_address = '0;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        l_req = 1'b0;
  logic        l_write = 1'b0;
  logic [3:0]  l_frame_mask = '0;
  logic [31:0] l_address = '0;
  logic [31:0] l_wdata = '0;
  logic        l_ack;
  logic [31:0] l_rdata;
  logic        err;
  logic        mem_enable;
  logic        mem_state;
  logic [3:0]  mem_frame_mask;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  arb_state_t  fsm_state;

  data_memory_arbiter #(
    .L_STREAK_MAX (4),
    .TIMEOUT      (255)
  ) dut (
    .CLK            (CLK),
    .reset_n        (reset_n),
    .f_req          (f_req),
    .f_address      (f_address),
    .f_ack          (f_ack),
    .f_rdata        (f_rdata),
    .l_req          (l_req),
    .l_write        (l_write),
    .l_frame_mask   (l_frame_mask),
    .l_address      (l_address),
    .l_wdata        (l_wdata),
    .l_ack          (l_ack),
    .l_rdata        (l_rdata),
    .err            (err),
    .mem_enable     (mem_enable),
    .mem_state      (mem_state),
    .mem_frame_mask (mem_frame_mask),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_done       (mem_done),
    .fsm_state      (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {port, err, rdata} expected at each ack
  logic [68:0] gnt_q[$];   // {mem_state, mask, address, wdata} expected at each grant
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input bit bad);
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
    end
  endtask

  function automatic logic [68:0] gnt(input logic st, input logic [3:0] m,
                                      input logic [31:0] a, input logic [31:0] d);
    return {st, m, a, d};
  endfunction

  function automatic logic [33:0] rsp(input logic port, input logic e, input logic [31:0] d);
    return {port, e, d};
  endfunction

  // ---------------- memory model ----------------
  int          resp_delay = 2;
  logic [31:0] resp_data = '0;
  bit          resp_never = 1'b0;
  bit          idle_done = 1'b0;
  int          busy_cnt = 0;

  always @(negedge CLK) begin
    if (mem_enable) begin
      mem_done  = !resp_never && (busy_cnt == resp_delay);
      mem_rdata = mem_done ? resp_data : 32'h0;
      busy_cnt++;
    end else begin
      busy_cnt  = 0;
      mem_done  = idle_done;
      mem_rdata = idle_done ? 32'hBAD0BAD0 : 32'h0;
    end
  end

  // ---------------- monitor ----------------
  logic prev_en = 1'b0;
  always @(negedge CLK) begin
    if (reset_n) begin
      if (mem_enable && !prev_en) begin
        if (gnt_q.size() == 0) flag("unexpected_grant", 1'b1);
        else check("grant_cmd", {mem_state, mem_frame_mask, mem_address, mem_wdata}, gnt_q.pop_front());
      end
      if (f_ack && l_ack) begin
        flag("double_ack", 1'b1);
      end else if (f_ack || l_ack) begin
        if (exp_q.size() == 0) flag("unexpected_ack", 1'b1);
        else check("ack_resp", {l_ack, err, (l_ack ? l_rdata : f_rdata)}, exp_q.pop_front());
      end
      if (err && !(f_ack || l_ack)) flag("err_without_ack", 1'b1);
    end
    prev_en = mem_enable;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acks(input int n, input int max_cycles, input bit drop, output int cycles);
    int seen = 0;
    cycles = 0;
    while (seen < n && cycles < max_cycles) begin
      @(negedge CLK);
      cycles++;
      if (f_ack) begin seen++; if (drop) f_req = 1'b0; end
      if (l_ack) begin seen++; if (drop) l_req = 1'b0; end
    end
    if (seen < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_wait: got %0d acks expected %0d", seen, n);
    end
  endtask

  task automatic set_l(input logic wr, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    l_write = wr;
    l_frame_mask = m;
    l_address = a;
    l_wdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int en_cnt;

    // reset state
    reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_state", fsm_state, IDLE);
    check("rst_mem_enable", mem_enable, 1'b0);
    check("rst_acks_err", {f_ack, l_ack, err}, 3'b000);
    check("rst_rdata", {f_rdata, l_rdata}, 64'h0);
    check("rst_mem_cmd", {mem_state, mem_frame_mask, mem_address, mem_wdata}, 69'h0);
    reset_n = 1'b1;
    @(negedge CLK);

    // 1: fetch only
    resp_delay = 2;
    resp_data = 32'hDEADBEEF;
    gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h100, 32'h0));
    exp_q.push_back(rsp(PORT_F, 1'b0, 32'hDEADBEEF));
    f_address = 32'h100;
    f_req = 1'b1;
    @(posedge CLK);
    #1;
    check("t1_enable_latency", mem_enable, 1'b1);
    wait_acks(1, 50, 1'b1, cyc);
    check("t1_ack_latency", cyc, 4);
    @(negedge CLK);
    check("t1_rdata_hold", f_rdata, 32'hDEADBEEF);
    check("t1_idle", fsm_state, IDLE);

    // 2: simultaneous requests, L store wins first
    resp_delay = 1;
    resp_data = 32'h0BADF00D;
    set_l(1'b1, 4'b0011, 32'h200, 32'h00001234);
    f_address = 32'h104;
    gnt_q.push_back(gnt(1'b1, 4'b0011, 32'h200, 32'h00001234));
    gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h104, 32'h0));
    exp_q.push_back(rsp(PORT_L, 1'b0, 32'h0));
    exp_q.push_back(rsp(PORT_F, 1'b0, 32'h0BADF00D));
    f_req = 1'b1;
    l_req = 1'b1;
    wait_acks(2, 100, 1'b1, cyc);
    repeat (2) @(negedge CLK);

    // 3: both held, streak forces every fifth grant to F
    resp_delay = 0;
    resp_data = 32'hCAFE0003;
    set_l(1'b0, 4'b1111, 32'h300, 32'h0);
    f_address = 32'h380;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) begin
        gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h380, 32'h0));
        exp_q.push_back(rsp(PORT_F, 1'b0, 32'hCAFE0003));
      end else begin
        gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h300, 32'h0));
        exp_q.push_back(rsp(PORT_L, 1'b0, 32'hCAFE0003));
      end
    end
    f_req = 1'b1;
    l_req = 1'b1;
    wait_acks(10, 200, 1'b0, cyc);
    f_req = 1'b0;
    l_req = 1'b0;
    check("t3_grant_spacing", cyc, 29);
    repeat (2) @(negedge CLK);

    // 4: L load with no mem_done -> timeout
    resp_never = 1'b1;
    set_l(1'b0, 4'b1111, 32'h600, 32'hFFFF0000);
    gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h600, 32'hFFFF0000));
    exp_q.push_back(rsp(PORT_L, 1'b1, 32'h0));
    l_req = 1'b1;
    en_cnt = 0;
    cyc = 0;
    while (!l_ack && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (mem_enable) en_cnt++;
    end
    l_req = 1'b0;
    check("t4_busy_cycles", en_cnt, 255);
    check("t4_ack_err", {l_ack, err}, 2'b11);
    @(negedge CLK);
    check("t4_idle", fsm_state, IDLE);
    check("t4_l_rdata", l_rdata, 32'h0);
    check("t4_err_clear", err, 1'b0);

    // 5: reset during BUSY
    f_address = 32'h700;
    gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h700, 32'h0));
    f_req = 1'b1;
    repeat (3) @(negedge CLK);
    check("t5_busy", mem_enable, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_reset_enable", mem_enable, 1'b0);
    check("t5_reset_state", fsm_state, IDLE);
    f_req = 1'b0;
    @(negedge CLK);
    check("t5_no_ack", {f_ack, l_ack, err}, 3'b000);
    reset_n = 1'b1;
    resp_never = 1'b0;
    resp_delay = 2;
    resp_data = 32'h5555AAAA;
    @(negedge CLK);
    f_address = 32'h704;
    gnt_q.push_back(gnt(1'b0, 4'b1111, 32'h704, 32'h0));
    exp_q.push_back(rsp(PORT_F, 1'b0, 32'h5555AAAA));
    f_req = 1'b1;
    wait_acks(1, 50, 1'b1, cyc);
    @(negedge CLK);

    // 6: mem_done while idle is ignored
    idle_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t6_idle_quiet", {mem_enable, f_ack, l_ack, err}, 4'b0000);
      check("t6_idle_state", fsm_state, IDLE);
    end
    idle_done = 1'b0;
    check("t6_f_rdata_kept", f_rdata, 32'h5555AAAA);

    repeat (3) @(negedge CLK);
    check("final_resp_queue", exp_q.size(), 0);
    check("final_grant_queue", gnt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
